wb_openram_arbiter: RTL and testbench

Parametrised successor to the two-master OpenRAM wrapper. It lets NUM_PORTS Wishbone classic slaves share one OpenRAM macro with one RW port (port 0) and one R port (port 1), all in a single clock domain. A registered round-robin scheduler places writes on port 0 and spreads reads over both RAM ports. It stalls reads that collide with a same-cycle write to the same word, and returns one-cycle acks with registered read data. It sits between the user-project Wishbone interconnect and the SRAM macro, replacing the static writable-port select.

---
 rtl/wb_openram_pkg.sv | 28 ++
 rtl/wb_openram_arbiter_if.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 40 ++++
 rtl/wb_openram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_openram_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_openram_pkg.sv
// Shared types and helpers for the Wishbone-to-OpenRAM arbiter.
// Port FSM states, constant log2 and byte-to-word address mapping.
package wb_openram_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ISSUE,
      S_CAPT,
      S_ACK
   } port_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic logic [31:0] word_addr(
      input logic [31:0] adr,
      input int          byte_bits
   );
      return adr >> byte_bits;
   endfunction

endpackage

// File: rtl/wb_openram_arbiter_if.sv
// Wishbone classic bundle for NUM_PORTS masters sharing one RAM.
// Buses are flat, port i occupying slice i of each vector.
interface wb_openram_arbiter_if
   import wb_openram_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int BYTE_BITS = clog2(SEL_WIDTH);
   localparam int AW        = ADDR_WIDTH + BYTE_BITS;

   logic [NUM_PORTS-1:0]            wbs_stb_i;
   logic [NUM_PORTS-1:0]            wbs_cyc_i;
   logic [NUM_PORTS-1:0]            wbs_we_i;
   logic [NUM_PORTS*SEL_WIDTH-1:0]  wbs_sel_i;
   logic [NUM_PORTS*AW-1:0]         wbs_adr_i;
   logic [NUM_PORTS*DATA_WIDTH-1:0] wbs_dat_i;
   logic [NUM_PORTS-1:0]            wbs_ack_o;
   logic [NUM_PORTS*DATA_WIDTH-1:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i,
      output wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
      input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_rr_arbiter.sv
// N-way round-robin arbiter with request mask and gated pointer update.
// Grant is combinational; the pointer moves past the winner only when en.
module wb_rr_arbiter
   import wb_openram_pkg::*;
#(
   parameter int  N  = 2,
   localparam int PW = (N > 1) ? clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic         any
);
   logic [PW-1:0] ptr;
   logic [PW-1:0] nxt;
   logic [N-1:0]  r;

   always_comb begin
      r   = req & ~mask;
      gnt = '0;
      any = 1'b0;
      nxt = ptr;
      for (int k = 0; k < N; k++)
         for (int i = 0; i < N; i++)
            if (!any && r[i] && i == (int'(ptr) + k) % N) begin
               any    = 1'b1;
               gnt[i] = 1'b1;
               nxt    = PW'((i + 1) % N);
            end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr <= '0;
      else if (en && any) ptr <= nxt;
   end

endmodule

// File: rtl/wb_openram_arbiter.sv
// NUM_PORTS Wishbone slaves sharing a 1RW+1R OpenRAM macro.
// Writes go to RAM port 0; reads spread over both ports.
module wb_openram_arbiter
   import wb_openram_pkg::*;
#(
   parameter int  NUM_PORTS  = 2,
   parameter int  ADDR_WIDTH = 8,
   parameter int  DATA_WIDTH = 32,
   localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   wb_openram_arbiter_if.slave   wbs,
   output logic                  ram_clk0,
   output logic                  ram_csb0,
   output logic                  ram_web0,
   output logic [SEL_WIDTH-1:0]  ram_wmask0,
   output logic [ADDR_WIDTH-1:0] ram_addr0,
   output logic [DATA_WIDTH-1:0] ram_din0,
   input  logic [DATA_WIDTH-1:0] ram_dout0,
   output logic                  ram_clk1,
   output logic                  ram_csb1,
   output logic [ADDR_WIDTH-1:0] ram_addr1,
   input  logic [DATA_WIDTH-1:0] ram_dout1
);
   localparam int BYTE_BITS = clog2(SEL_WIDTH);
   localparam int AW        = ADDR_WIDTH + BYTE_BITS;
   localparam int DW        = DATA_WIDTH;
   localparam int SW        = SEL_WIDTH;

   logic [1:0]            rst_sync;
   logic                  rst_n;
   port_state_e           state  [NUM_PORTS];
   logic [ADDR_WIDTH-1:0] wadr   [NUM_PORTS];
   logic [DW-1:0]         rdat_q [NUM_PORTS];
   logic [NUM_PORTS-1:0]  pend, wr_req, rd_req, req0;
   logic [NUM_PORTS-1:0]  gnt0, gnt1, we_q, src_q, ack_q;
   logic                  g0_any, g1_any, g0_we, g1_ok, hazard;
   logic [ADDR_WIDTH-1:0] g0_adr, g1_adr;
   logic [SW-1:0]         g0_sel;
   logic [DW-1:0]         g0_dat;

   assign ram_clk0 = wb_clk_i;
   assign ram_clk1 = wb_clk_i;

   // assert asynchronously, release two clocks later
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) rst_sync <= '0;
      else             rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         pend[i]   = wbs.wbs_cyc_i[i] & wbs.wbs_stb_i[i] &
                     (state[i] == S_IDLE || state[i] == S_WAIT);
         wr_req[i] = pend[i] & wbs.wbs_we_i[i];
         rd_req[i] = pend[i] & ~wbs.wbs_we_i[i];
         wadr[i]   = ADDR_WIDTH'(word_addr(
                        32'(wbs.wbs_adr_i[i*AW +: AW]), BYTE_BITS));
      end
   end

   assign req0 = |wr_req ? wr_req : rd_req;

   wb_rr_arbiter #(.N(NUM_PORTS)) u_arb0 (
      .clk   (wb_clk_i),
      .rst_n (rst_n),
      .req   (req0),
      .mask  ('0),
      .en    (1'b1),
      .gnt   (gnt0),
      .any   (g0_any)
   );

   wb_rr_arbiter #(.N(NUM_PORTS)) u_arb1 (
      .clk   (wb_clk_i),
      .rst_n (rst_n),
      .req   (rd_req),
      .mask  (gnt0),
      .en    (~hazard),
      .gnt   (gnt1),
      .any   (g1_any)
   );

   always_comb begin
      g0_we  = 1'b0;
      g0_adr = '0;
      g0_sel = '0;
      g0_dat = '0;
      g1_adr = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt0[i]) begin
            g0_we  = wbs.wbs_we_i[i];
            g0_adr = wadr[i];
            g0_sel = wbs.wbs_sel_i[i*SW +: SW];
            g0_dat = wbs.wbs_dat_i[i*DW +: DW];
         end
         if (gnt1[i]) g1_adr = wadr[i];
      end
   end

   // a read of the word being written this cycle waits a cycle
   assign hazard = g0_any & g0_we & g1_any & (g1_adr == g0_adr);
   assign g1_ok  = g1_any & ~hazard;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            state[i]  <= S_IDLE;
            rdat_q[i] <= '0;
         end
         we_q  <= '0;
         src_q <= '0;
         ack_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            ack_q[i] <= 1'b0;
            unique case (state[i])
               S_IDLE, S_WAIT: begin
                  if (gnt0[i] || (gnt1[i] && g1_ok)) begin
                     state[i] <= S_ISSUE;
                     we_q[i]  <= wbs.wbs_we_i[i];
                     src_q[i] <= ~gnt0[i];
                  end else if (pend[i]) begin
                     state[i] <= S_WAIT;
                  end else begin
                     state[i] <= S_IDLE;
                  end
               end
               S_ISSUE: begin
                  if (we_q[i]) begin
                     state[i] <= S_ACK;
                     ack_q[i] <= 1'b1;
                  end else begin
                     state[i] <= S_CAPT;
                  end
               end
               S_CAPT: begin
                  state[i]  <= S_ACK;
                  ack_q[i]  <= 1'b1;
                  rdat_q[i] <= src_q[i] ? ram_dout1 : ram_dout0;
               end
               S_ACK:   state[i] <= S_IDLE;
               default: state[i] <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ram_csb0   <= 1'b1;
         ram_web0   <= 1'b1;
         ram_wmask0 <= '0;
         ram_addr0  <= '0;
         ram_din0   <= '0;
         ram_csb1   <= 1'b1;
         ram_addr1  <= '0;
      end else begin
         // a write with no byte lanes is acked but never reaches the macro
         ram_csb0 <= ~(g0_any & (~g0_we | (|g0_sel)));
         ram_web0 <= ~(g0_any & g0_we & (|g0_sel));
         if (g0_any) begin
            ram_addr0  <= g0_adr;
            ram_wmask0 <= g0_we ? g0_sel : '0;
            ram_din0   <= g0_we ? g0_dat : '0;
         end
         ram_csb1 <= ~g1_ok;
         if (g1_ok) ram_addr1 <= g1_adr;
      end
   end

   assign wbs.wbs_ack_o = ack_q & wbs.wbs_cyc_i;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dat
      assign wbs.wbs_dat_o[i*DW +: DW] = rdat_q[i];
   end

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Directed bench: 2-port instance with a RAM model, 4-port for fairness.
// Table vectors for single transactions plus scripted corner sequences.
module tb_wb_openram_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   wb_openram_arbiter_if #(.NUM_PORTS(2)) bus2 ();
   wb_openram_arbiter_if #(.NUM_PORTS(4)) bus4 ();

   logic        r_clk0, r_clk1, r_csb0, r_web0, r_csb1;
   logic [3:0]  r_wmask0;
   logic [7:0]  r_addr0, r_addr1;
   logic [31:0] r_din0, r_dout0, r_dout1;

   logic        q_clk0, q_clk1, q_csb0, q_web0, q_csb1;
   logic [3:0]  q_wmask0;
   logic [7:0]  q_addr0, q_addr1;
   logic [31:0] q_din0;

   wb_openram_arbiter #(
      .NUM_PORTS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)
   ) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(bus2),
      .ram_clk0(r_clk0), .ram_csb0(r_csb0), .ram_web0(r_web0),
      .ram_wmask0(r_wmask0), .ram_addr0(r_addr0),
      .ram_din0(r_din0), .ram_dout0(r_dout0),
      .ram_clk1(r_clk1), .ram_csb1(r_csb1),
      .ram_addr1(r_addr1), .ram_dout1(r_dout1)
   );

   wb_openram_arbiter #(
      .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)
   ) dut4 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(bus4),
      .ram_clk0(q_clk0), .ram_csb0(q_csb0), .ram_web0(q_web0),
      .ram_wmask0(q_wmask0), .ram_addr0(q_addr0),
      .ram_din0(q_din0), .ram_dout0(32'h0),
      .ram_clk1(q_clk1), .ram_csb1(q_csb1),
      .ram_addr1(q_addr1), .ram_dout1(32'h0)
   );

   // behavioural macro: one-cycle read latency, masked writes
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (!r_csb0) begin
         if (!r_web0) begin
            for (int b = 0; b < 4; b++)
               if (r_wmask0[b]) mem[r_addr0][b*8 +: 8] <= r_din0[b*8 +: 8];
         end else begin
            r_dout0 <= mem[r_addr0];
         end
      end
      if (!r_csb1) r_dout1 <= mem[r_addr1];
   end

   typedef struct {
      int          port;
      bit          we;
      logic [3:0]  sel;
      logic [7:0]  word;
      logic [31:0] wdat;
      logic [31:0] exp;
      int          lat;
      bit          acc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive2(input int p, input bit we, input logic [3:0] sel,
                         input logic [7:0] word, input logic [31:0] d);
      bus2.wbs_cyc_i[p] = 1'b1;
      bus2.wbs_stb_i[p] = 1'b1;
      bus2.wbs_we_i[p]  = we;
      bus2.wbs_sel_i[p*4 +: 4]   = sel;
      bus2.wbs_adr_i[p*10 +: 10] = {word, 2'b00};
      bus2.wbs_dat_i[p*32 +: 32] = d;
   endtask

   task automatic drop2(input int p);
      bus2.wbs_cyc_i[p] = 1'b0;
      bus2.wbs_stb_i[p] = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " csb0"}, 32'(r_csb0), 32'h1);
      chk({tag, " csb1"}, 32'(r_csb1), 32'h1);
      chk({tag, " web0"}, 32'(r_web0), 32'h1);
      chk({tag, " wmask0"}, 32'(r_wmask0), 32'h0);
      chk({tag, " addr0"}, 32'(r_addr0), 32'h0);
      chk({tag, " din0"}, r_din0, 32'h0);
      chk({tag, " addr1"}, 32'(r_addr1), 32'h0);
      chk({tag, " ack"}, 32'(bus2.wbs_ack_o), 32'h0);
      chk({tag, " dat0"}, bus2.wbs_dat_o[31:0], 32'h0);
      chk({tag, " dat1"}, bus2.wbs_dat_o[63:32], 32'h0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int got;
      bit acc;
      got = -1;
      acc = 1'b0;
      next_cycle();
      drive2(v.port, v.we, v.sel, v.word, v.wdat);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (!r_csb0 || !r_csb1) acc = 1'b1;
         if (bus2.wbs_ack_o[v.port]) begin
            got = n;
            break;
         end
      end
      chk($sformatf("vec%0d latency", idx), 32'(got), 32'(v.lat));
      if (!v.we)
         chk($sformatf("vec%0d rdata", idx),
             bus2.wbs_dat_o[v.port*32 +: 32], v.exp);
      next_cycle();
      drop2(v.port);
      chk($sformatf("vec%0d ram access", idx), 32'(acc), 32'(v.acc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g [8];
      int gi;
      bit seen;
      logic [31:0] s;

      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[5] <= 32'hDEADBEEF;

      bus2.wbs_cyc_i = '0; bus2.wbs_stb_i = '0; bus2.wbs_we_i = '0;
      bus2.wbs_sel_i = '0; bus2.wbs_adr_i = '0; bus2.wbs_dat_i = '0;
      bus4.wbs_cyc_i = '0; bus4.wbs_stb_i = '0; bus4.wbs_we_i = '0;
      bus4.wbs_sel_i = '0; bus4.wbs_adr_i = '0; bus4.wbs_dat_i = '0;

      vecs[0] = '{0, 1'b0, 4'hF, 8'd5,   32'h0,        32'hDEADBEEF, 3, 1'b1};
      vecs[1] = '{1, 1'b1, 4'hF, 8'd10,  32'hAABBCCDD, 32'h0,        2, 1'b1};
      vecs[2] = '{0, 1'b0, 4'hF, 8'd10,  32'h0,        32'hAABBCCDD, 3, 1'b1};
      vecs[3] = '{0, 1'b1, 4'h3, 8'd10,  32'h11112222, 32'h0,        2, 1'b1};
      vecs[4] = '{1, 1'b0, 4'hF, 8'd10,  32'h0,        32'hAABB2222, 3, 1'b1};
      vecs[5] = '{1, 1'b1, 4'h0, 8'd10,  32'hFFFFFFFF, 32'h0,        2, 1'b0};
      vecs[6] = '{0, 1'b0, 4'hF, 8'd10,  32'h0,        32'hAABB2222, 3, 1'b1};
      vecs[7] = '{1, 1'b1, 4'h8, 8'd255, 32'h12345678, 32'h0,        2, 1'b1};
      vecs[8] = '{0, 1'b0, 4'hF, 8'd255, 32'h0,        32'h12000000, 3, 1'b1};

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      repeat (4) next_cycle();

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // single read: controls in T+1, ack with data in T+3
      next_cycle();
      drive2(0, 1'b0, 4'hF, 8'd5, 32'h0);
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("single csb0", 32'(r_csb0), 32'h0);
      chk("single web0", 32'(r_web0), 32'h1);
      chk("single addr0", 32'(r_addr0), 32'd5);
      next_cycle();
      @(negedge clk);
      chk("single ack T+2", 32'(bus2.wbs_ack_o[0]), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("single ack T+3", 32'(bus2.wbs_ack_o[0]), 32'h1);
      chk("single data", bus2.wbs_dat_o[31:0], 32'hDEADBEEF);
      next_cycle();
      drop2(0);
      chk("single ack once", 32'(bus2.wbs_ack_o[0]), 32'h0);

      // two reads served by both RAM ports in the same cycle
      next_cycle();
      drive2(0, 1'b0, 4'hF, 8'd1, 32'h0);
      drive2(1, 1'b0, 4'hF, 8'd2, 32'h0);
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("simul csb0", 32'(r_csb0), 32'h0);
      chk("simul csb1", 32'(r_csb1), 32'h0);
      chk("simul addr pair",
          32'((r_addr0 == 8'd1 && r_addr1 == 8'd2) ||
              (r_addr0 == 8'd2 && r_addr1 == 8'd1)), 32'h1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("simul acks", 32'(bus2.wbs_ack_o), 32'h3);
      chk("simul dat0", bus2.wbs_dat_o[31:0], 32'h11111111);
      chk("simul dat1", bus2.wbs_dat_o[63:32], 32'h22222222);
      next_cycle();
      drop2(0);
      drop2(1);

      // write and read of the same word in one cycle
      next_cycle();
      drive2(0, 1'b1, 4'hF, 8'd7, 32'hCAFEF00D);
      drive2(1, 1'b0, 4'hF, 8'd7, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("hazard T+1 csb0", 32'(r_csb0), 32'h0);
      chk("hazard T+1 web0", 32'(r_web0), 32'h0);
      chk("hazard T+1 addr0", 32'(r_addr0), 32'd7);
      chk("hazard T+1 csb1", 32'(r_csb1), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("hazard write ack", 32'(bus2.wbs_ack_o[0]), 32'h1);
      chk("hazard T+2 read csb0", 32'(r_csb0), 32'h0);
      chk("hazard T+2 read web0", 32'(r_web0), 32'h1);
      chk("hazard T+2 read addr0", 32'(r_addr0), 32'd7);
      next_cycle();
      drop2(0);
      @(negedge clk);
      chk("hazard read ack T+3", 32'(bus2.wbs_ack_o[1]), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("hazard read ack T+4", 32'(bus2.wbs_ack_o[1]), 32'h1);
      chk("hazard read data", bus2.wbs_dat_o[63:32], 32'hCAFEF00D);
      next_cycle();
      drop2(1);

      // port 1 aborts while held in WAIT
      next_cycle();
      drive2(0, 1'b1, 4'hF, 8'd9, 32'h00000099);
      drive2(1, 1'b0, 4'hF, 8'd9, 32'h0);
      next_cycle();
      drop2(1);
      @(negedge clk);
      chk("abort write csb0", 32'(r_csb0), 32'h0);
      chk("abort csb1", 32'(r_csb1), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("abort write ack", 32'(bus2.wbs_ack_o[0]), 32'h1);
      chk("abort no read csb0", 32'(r_csb0), 32'h1);
      next_cycle();
      drop2(0);
      seen = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (bus2.wbs_ack_o[1] || !r_csb0 || !r_csb1) seen = 1'b1;
      end
      chk("abort quiet", 32'(seen), 32'h0);

      // four writers: port 0 grants rotate
      next_cycle();
      bus4.wbs_cyc_i = 4'hF;
      bus4.wbs_stb_i = 4'hF;
      bus4.wbs_we_i  = 4'hF;
      bus4.wbs_sel_i = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         bus4.wbs_adr_i[i*10 +: 10] = {8'(i), 2'b00};
         bus4.wbs_dat_i[i*32 +: 32] = 32'(i) + 32'hA0;
      end
      gi = 0;
      for (int c = 0; c < 40 && gi < 8; c++) begin
         @(negedge clk);
         if (!q_csb0) begin
            g[gi] = int'(q_addr0);
            gi++;
         end
      end
      chk("fair grant count", 32'(gi), 32'd8);
      for (int k = 0; k < 8; k++)
         if (k < gi) chk($sformatf("fair grant %0d", k), 32'(g[k]), 32'(k % 4));
      next_cycle();
      bus4.wbs_cyc_i = '0;
      bus4.wbs_stb_i = '0;

      // reset asserted during the capture cycle of a read
      repeat (3) next_cycle();
      drive2(0, 1'b0, 4'hF, 8'd5, 32'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      #1;
      chk_reset("pulse");
      drop2(0);
      next_cycle();
      rst_n = 1'b1;
      drive2(0, 1'b0, 4'hF, 8'd5, 32'h0);
      seen = 1'b0;
      @(negedge clk);
      if (bus2.wbs_ack_o[0]) seen = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("release R1 csb0", 32'(r_csb0), 32'h1);
      if (bus2.wbs_ack_o[0]) seen = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("release R2 csb0", 32'(r_csb0), 32'h1);
      if (bus2.wbs_ack_o[0]) seen = 1'b1;
      chk("no ack after reset", 32'(seen), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("release R3 csb0", 32'(r_csb0), 32'h0);
      s = 32'hFFFFFFFF;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (bus2.wbs_ack_o[0]) begin
            s = 32'(n);
            break;
         end
      end
      chk("post-reset ack delay", s, 32'd1);
      chk("post-reset data", bus2.wbs_dat_o[31:0], 32'hDEADBEEF);
      next_cycle();
      drop2(0);
      repeat (2) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
